fp_postnormalization: RTL and testbench
=======================================

Name: fp_postnormalization

Overview:
- Output stage of the FP adder/subtractor. It sits downstream of the alignment (prenormalization) stage and the mantissa adder.
- Takes the raw 25-bit mantissa sum (with carry), the common exponent, the result sign and the guard/round/sticky bits. It normalizes iteratively, rounds to nearest-even and packs an IEEE-754 single.
- Uses a valid/ready handshake on both sides, so it tolerates a variable cycle count and downstream backpressure.

Parameters:
- MANT_W, 24, significand width including the hidden bit.
- EXP_W, 8, exponent field width.
- EXP_MAX, 255, all-ones exponent (Inf).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input bundle valid
- in_ready  output  1  block can accept; high only in IDLE
- sign_in  input  1  result sign
- exp_in  input  8  common exponent from alignment; 0 = both operands subnormal
- mant_in  input  25  raw sum; bit24 = carry, bit23 = hidden position
- grs_in  input  3  guard, round, sticky from alignment shift-out
- out_valid  output  1  FP_out valid
- out_ready  input  1  downstream accepts
- FP_out  output  32  packed IEEE-754 result
- overflow  output  1  result rounded to Inf
- underflow  output  1  result subnormal or zero from a nonzero sum
- inexact  output  1  any of g/r/s was set before rounding

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; out_valid = 0; FP_out = 0; all flags = 0; internal registers = 0.
  - in_ready = 1 once released.
  - Reset in any state aborts the operation and discards its result.
- States: IDLE, CHECK, NORM, ROUND, DONE.
- IDLE:
  - in_valid & in_ready captures sign, exp, mant and grs, then moves to CHECK.
  - If exp_in == 0, the effective exponent is 1 (subnormal alignment).
- CHECK:
  - mant == 0 and grs == 0: FP_out = {sign,31'b0}; underflow = 0; go to DONE.
  - mant[24] set: shift right 1. New g = mant[0], r = old g, s = old r | old s. exp += 1. Go to ROUND.
  - mant[23] set: go to ROUND.
  - Otherwise: go to NORM.
- NORM (one left shift per cycle):
  - mant = {mant[22:0], g}; g = r; r = 0; s unchanged; exp -= 1.
  - Exit to ROUND on the edge where the shifted mant[23] == 1 or exp reaches 1.
  - If exp is already 1 on entry, exit to ROUND with no shift.
  - Maximum 23 iterations.
- ROUND:
  - round_up = g & (r | s | mant[0]); inexact = g | r | s.
  - Add round_up to mant.
  - If the add carries to bit24: shift right 1, exp += 1.
  - If exp == 255: FP_out = {sign, 8'hFF, 23'b0}; overflow = 1.
  - Else if mant[23] == 0 (subnormal): exponent field = 0; underflow = 1.
  - A subnormal that rounds into bit23 gets exponent field 1 and underflow = 0.
  - Go to DONE.
- DONE:
  - out_valid = 1; FP_out and flags stay stable while out_ready is low.
  - On out_valid & out_ready: out_valid drops and the state returns to IDLE.
  - The earliest next accept is the following cycle. Input is not accepted in the same cycle as the output handshake.
- Latency, counted in edges from the accept edge to out_valid high:
  - zero: 1
  - carry or already normalized: 2
  - N left shifts: 2 + N
- Flags are updated only when a new result is produced. They clear on the next accept.
- Inf and NaN inputs are out of scope; special cases are handled upstream.

Decomposition:
- Shared package fp_pkg holds:
  - state enum
  - EXP_MAX and BIAS (127)
  - field slice constants: SIGN_BIT 31, EXP_HI 30, EXP_LO 23, MANT_HI 22
  - round-to-nearest-even helper function
- Optional sub-module fp_round_rne: combinational g/r/s/lsb → round_up plus incremented mantissa with carry-out. Keep the FSM and shifter in the top module.

Test Plan:
- 1.0+1.0: exp 127, mant 0x1000000, grs 000 → FP_out 0x40000000, latency 2, all flags 0.
- Cancellation: exp 127, mant 0x0400000 → one shift → 0x3F000000, latency 3. Second case: mant 0x0000001, exp 127 → 23 shifts → 0x34000000, latency 25.
- Zero sum: mant 0, grs 000, sign 1 → 0x80000000, latency 1; with sign 0 → 0x00000000.
- RNE:
  - exp 127, mant 0x0800001, grs 100 → 0x3F800002, inexact 1.
  - mant 0x0800000, grs 100 → 0x3F800000 (tie to even), inexact 1.
  - grs 101 → 0x3F800001.
- Overflow: exp 254, mant 0x1FFFFFE → exp 255 → 0x7F800000, overflow 1. Subnormal: exp 1, mant 0x0400000 → 0x00400000, underflow 1. Both-subnormal carry: exp 0, mant 0x0800000 → 0x00800000, underflow 0.
- Handshake/reset:
  - Hold out_ready low 5 cycles → FP_out and out_valid stable; in_ready stays 0.
  - Assert rst_n low mid-NORM → all outputs 0 immediately; next operation is correct.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and rounding helper for the FP
// adder/subtractor output stage.
package fp_pkg;

  // Operand geometry: significand includes the hidden bit.
  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  // Bit positions inside a packed IEEE-754 single.
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MANT_HI  = 22;

  // FSM encoding, kept as plain constants so checkers can bind to the
  // raw state bits.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_NORM  = 3'd2;
  localparam state_t ST_ROUND = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Round-to-nearest, ties-to-even: increment when the guard bit is set and
  // either something below it is set or the kept lsb is odd.
  function automatic logic rne_round_up(input logic g, input logic r,
                                        input logic s, input logic lsb);
    return g & (r | s | lsb);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational RNE rounder: decides the increment from g/r/s and the lsb,
// and returns the incremented significand with its carry-out.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  output logic              round_up,
  output logic [MANT_W-1:0] mant_rnd,
  output logic              carry
);

  assign round_up = rne_round_up(g, r, s, mant[0]);

  // Carry-out means the significand rolled over to 2.0 and must be
  // renormalized by the caller.
  assign {carry, mant_rnd} = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};

endmodule

// File: rtl/fp_postnormalization.sv
// Post-normalization stage of the FP adder/subtractor: normalizes the raw
// mantissa sum one bit per cycle, rounds to nearest-even and packs a single.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, in_ready is high only in IDLE,
// and out_valid with FP_out/flags holds steady until out_ready is seen.
module fp_postnormalization
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [EXP_W-1:0]    exp_in,
  input  logic [MANT_W:0]     mant_in,
  input  logic [2:0]          grs_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         FP_out,
  output logic                overflow,
  output logic                underflow,
  output logic                inexact,
  output logic [2:0]          dbg_state
);

  // Two spare exponent bits so carry increments can never wrap.
  localparam logic [EXP_W+1:0] EXP_ONE = 10'd1;
  localparam logic [EXP_W+1:0] EXP_TWO = 10'd2;
  localparam logic [EXP_W+1:0] EXP_INF = 10'(EXP_MAX);
  localparam logic [4:0]       LAST_SHIFT = 5'd22;

  state_t              state;
  logic                sign_r;
  logic [EXP_W+1:0]    exp_r;
  logic [MANT_W:0]     mant_r;
  logic                g_r;
  logic                r_r;
  logic                s_r;
  logic [4:0]          cnt_r;

  logic [MANT_W-1:0]   mant_sh;
  logic                round_up;
  logic [MANT_W-1:0]   mant_rnd;
  logic                rnd_carry;
  logic [MANT_W-1:0]   mant_fin;
  logic [EXP_W+1:0]    exp_fin;
  logic [31:0]         fp_next;
  logic                ov_next;
  logic                uf_next;

  // in_ready is held low while reset is asserted.
  assign in_ready  = rst_n && (state == ST_IDLE);
  assign dbg_state = state;

  // One left-shift step: the guard bit refills the vacated lsb.
  assign mant_sh = {mant_r[MANT_W-2:0], g_r};

  fp_round_rne u_round (
    .mant     (mant_r[MANT_W-1:0]),
    .g        (g_r),
    .r        (r_r),
    .s        (s_r),
    .round_up (round_up),
    .mant_rnd (mant_rnd),
    .carry    (rnd_carry)
  );

  // Renormalize after rounding if the increment overflowed the significand.
  always_comb begin
    mant_fin = mant_rnd;
    exp_fin  = exp_r;
    if (rnd_carry) begin
      mant_fin = {1'b1, mant_rnd[MANT_W-1:1]};
      exp_fin  = exp_r + EXP_ONE;
    end
  end

  // Pack the rounded result: Inf on exponent overflow, exponent field 0 when
  // the hidden bit is still clear, normal encoding otherwise.
  always_comb begin
    fp_next           = '0;
    ov_next           = 1'b0;
    uf_next           = 1'b0;
    fp_next[SIGN_BIT] = sign_r;
    if (exp_fin >= EXP_INF) begin
      fp_next[EXP_HI:EXP_LO] = '1;
      ov_next                = 1'b1;
    end else if (!mant_fin[MANT_W-1]) begin
      fp_next[MANT_HI:0] = mant_fin[MANT_W-2:0];
      uf_next            = 1'b1;
    end else begin
      fp_next[EXP_HI:EXP_LO] = exp_fin[EXP_W-1:0];
      fp_next[MANT_HI:0]     = mant_fin[MANT_W-2:0];
    end
  end

  // Control FSM plus the datapath registers it steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
      g_r       <= 1'b0;
      r_r       <= 1'b0;
      s_r       <= 1'b0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      FP_out    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign_r    <= sign_in;
            // Both-subnormal sums are aligned as if the exponent were 1.
            exp_r     <= (exp_in == '0) ? EXP_ONE : {2'b00, exp_in};
            mant_r    <= mant_in;
            g_r       <= grs_in[2];
            r_r       <= grs_in[1];
            s_r       <= grs_in[0];
            cnt_r     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            state     <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (mant_r == '0 && !g_r && !r_r && !s_r) begin
            // Exact cancellation: signed zero, no rounding needed.
            FP_out    <= {sign_r, 31'b0};
            underflow <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (mant_r[MANT_W]) begin
            // Carry out of the adder: one right shift folds into g/r/s.
            mant_r <= {1'b0, mant_r[MANT_W:1]};
            g_r    <= mant_r[0];
            r_r    <= g_r;
            s_r    <= r_r | s_r;
            exp_r  <= exp_r + EXP_ONE;
            state  <= ST_ROUND;
          end else if (mant_r[MANT_W-1]) begin
            state <= ST_ROUND;
          end else begin
            state <= ST_NORM;
          end
        end

        ST_NORM: begin
          if (exp_r == EXP_ONE) begin
            // Already at the minimum exponent: stays subnormal.
            state <= ST_ROUND;
          end else begin
            mant_r <= {1'b0, mant_sh};
            g_r    <= r_r;
            r_r    <= 1'b0;
            exp_r  <= exp_r - EXP_ONE;
            cnt_r  <= cnt_r + 5'd1;
            // Stop once the hidden bit is set, the exponent bottoms out, or
            // the 23-shift limit is hit.
            if (mant_sh[MANT_W-1] || exp_r == EXP_TWO || cnt_r == LAST_SHIFT) begin
              state <= ST_ROUND;
            end
          end
        end

        ST_ROUND: begin
          FP_out    <= fp_next;
          overflow  <= ov_next;
          underflow <= uf_next;
          inexact   <= g_r | r_r | s_r;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_postnormalization.sv
// Self-checking bench for fp_postnormalization: directed cases pinned to
// hand-computed literals, then randomized operations scored against a
// behavioural model, with random output backpressure.
module tb_fp_postnormalization;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic [2:0]  grs_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] FP_out;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic [2:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  logic [2:0]  flag_q[$];
  int          lat_q[$];
  int          acc_q[$];
  bit          seen = 0;
  bit          stall_req = 0;
  int          stall_cnt = 0;

  fp_postnormalization dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .grs_in    (grs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .FP_out    (FP_out),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .dbg_state (dbg_state)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: applies the normalize/round/pack rules with plain
  // integer arithmetic.
  function automatic void model(input logic sgn, input logic [7:0] ein,
                                input logic [24:0] min, input logic [2:0] grs,
                                output logic [31:0] fp, output logic [2:0] fl,
                                output int lat);
    int e, m, n;
    bit g, r, s, ov, uf, ix, up;
    logic [31:0] mv, ev;
    e = (ein == 0) ? 1 : int'(ein);
    m = int'(min);
    g = grs[2]; r = grs[1]; s = grs[0];
    ov = 0; uf = 0;
    if (m == 0 && grs == 3'b000) begin
      fp = {sgn, 31'b0}; fl = 3'b000; lat = 1;
      return;
    end
    if (m >= (1 << 24)) begin
      s = r | s; r = g; g = (m % 2) == 1; m = m / 2; e = e + 1; lat = 2;
    end else if (m >= (1 << 23)) begin
      lat = 2;
    end else begin
      n = 0;
      while (e > 1 && m < (1 << 23) && n < 23) begin
        m = m * 2 + int'(g); g = r; r = 0; e = e - 1; n = n + 1;
      end
      lat = (n == 0) ? 3 : 2 + n;
    end
    ix = g | r | s;
    up = g && (r || s || (m % 2) == 1);
    m = m + int'(up);
    if (m >= (1 << 24)) begin m = m / 2; e = e + 1; end
    mv = m; ev = e;
    if (e >= 255) begin
      fp = {sgn, 8'hFF, 23'b0}; ov = 1;
    end else if (m < (1 << 23)) begin
      fp = {sgn, 8'h00, mv[22:0]}; uf = 1;
    end else begin
      fp = {sgn, ev[7:0], mv[22:0]};
    end
    fl = {ov, uf, ix};
  endfunction

  // Driver: present one bundle, wait (bounded) for in_ready, log expectation.
  task automatic send(input logic sgn, input logic [7:0] e, input logic [24:0] m,
                      input logic [2:0] grs);
    logic [31:0] fp;
    logic [2:0]  fl;
    int          lat;
    int          waited;
    @(negedge clk);
    sign_in = sgn; exp_in = e; mant_in = m; grs_in = grs; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", waited);
      in_valid = 1'b0;
      return;
    end
    model(sgn, e, m, grs, fp, fl, lat);
    exp_q.push_back(fp);
    flag_q.push_back(fl);
    lat_q.push_back(lat);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Directed case: pin the model to a hand-computed literal, then run it.
  task automatic directed(input string name, input logic sgn, input logic [7:0] e,
                          input logic [24:0] m, input logic [2:0] grs,
                          input logic [31:0] want_fp, input logic [2:0] want_fl,
                          input int want_lat);
    logic [31:0] fp;
    logic [2:0]  fl;
    int          lat;
    model(sgn, e, m, grs, fp, fl, lat);
    chk({name, "_model_fp"}, fp, want_fp);
    chk({name, "_model_flags"}, {29'b0, fl}, {29'b0, want_fl});
    chk({name, "_model_lat"}, lat, want_lat);
    send(sgn, e, m, grs);
  endtask

  // Scoreboard: check every cycle out_valid is high against the front
  // expectation, then pick out_ready for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); flag_q.delete(); lat_q.delete(); acc_q.delete();
      seen = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_output: out_valid 1 with FP_out %h, required no output", FP_out);
        end else begin
          if (!seen) begin
            chk("latency", cyc - acc_q[0], lat_q[0]);
            seen = 1;
            if (stall_req) begin stall_cnt = 5; stall_req = 0; end
          end
          chk("fp_out", FP_out, exp_q[0]);
          chk("flags", {29'b0, overflow, underflow, inexact}, {29'b0, flag_q[0]});
          chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        end
      end else if (acc_q.size() > 0 && cyc - acc_q[0] > 40) begin
        n_cmp++; n_fail++;
        $display("FAIL output_timeout: out_valid 0 after %0d cycles, required 1", cyc - acc_q[0]);
        exp_q.delete(); flag_q.delete(); lat_q.delete(); acc_q.delete();
        seen = 0;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready && seen) begin
        void'(exp_q.pop_front()); void'(flag_q.pop_front());
        void'(lat_q.pop_front()); void'(acc_q.pop_front());
        seen = 0;
      end
    end
  end

  // Stimulus
  initial begin
    int cls, waited;
    logic [24:0] m;
    logic [7:0]  e;
    logic [2:0]  grs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign_in = 1'b0; exp_in = '0; mant_in = '0; grs_in = '0;
    #2;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_fp_out", FP_out, 32'h0);
    chk("reset_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    directed("one_plus_one", 0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2);
    directed("cancel_one",   0, 8'd127, 25'h0400000, 3'b000, 32'h3F000000, 3'b000, 3);
    directed("cancel_23",    0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 3'b000, 25);
    directed("zero_neg",     1, 8'd127, 25'h0000000, 3'b000, 32'h80000000, 3'b000, 1);
    directed("zero_pos",     0, 8'd127, 25'h0000000, 3'b000, 32'h00000000, 3'b000, 1);
    directed("rne_odd",      0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001, 2);
    directed("rne_tie_even", 0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001, 2);
    directed("rne_sticky",   0, 8'd127, 25'h0800000, 3'b101, 32'h3F800001, 3'b001, 2);
    directed("overflow",     0, 8'd254, 25'h1FFFFFE, 3'b000, 32'h7F800000, 3'b100, 2);
    directed("subnormal",    0, 8'd1,   25'h0400000, 3'b000, 32'h00400000, 3'b010, 3);
    directed("sub_carry",    0, 8'd0,   25'h0800000, 3'b000, 32'h00800000, 3'b000, 2);
    directed("sub_rnd_up",   0, 8'd1,   25'h07FFFFF, 3'b110, 32'h00800000, 3'b001, 3);

    // Backpressure: hold out_ready low for 5 cycles once the result appears.
    stall_req = 1;
    directed("stall", 1, 8'd130, 25'h1000003, 3'b011, 32'hC1800002, 3'b001, 2);

    // Reset in the middle of a long normalization.
    send(0, 8'd127, 25'h0000001, 3'b000);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_fp_out", FP_out, 32'h0);
    chk("midreset_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    directed("after_reset", 0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2);

    // Randomized operations.
    for (int i = 0; i < 150; i++) begin
      cls = $urandom_range(0, 9);
      grs = 3'($urandom_range(0, 7));
      case (cls)
        0, 1:    m = 25'h1000000 | 25'($urandom_range(0, 32'hFFFFFF));
        2, 3:    m = 25'h0800000 | 25'($urandom_range(0, 32'h7FFFFF));
        4, 5, 6: m = 25'($urandom_range(1, 32'h7FFFFF)) >> $urandom_range(0, 22);
        7:       m = 25'h0FFFFFF;
        default: begin m = '0; if ($urandom_range(0, 1) == 1) grs = 3'b000; end
      endcase
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(0, 6));
        1:       e = 8'($urandom_range(248, 254));
        default: e = 8'($urandom_range(0, 254));
      endcase
      send(1'($urandom_range(0, 1)), e, m, grs);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
